// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the single-cycle CPU front end.
//   pc_state_e       : sequencer state of pc_next_unit (BOOT / RUN / HOLD)
//   WORD_BYTES       : bytes per instruction word (sequential PC stride)
//   DEFAULT_RESET_PC : PC loaded on reset unless overridden by the instance
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } pc_state_e;

  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/branch_target_adder.sv
// -----------------------------------------------------------------------------
// branch_target_adder
// Computes the redirect target shared by the branch and jump paths:
//   target = pc_plus4 + (sign_extend(offset) << 2), modulo 2^32.
// Ports:
//   pc_plus4 [31:0]       in  : address of the following instruction
//   offset   [OFFSET_W-1:0] in : signed word offset from the instruction
//   target   [31:0]       out : redirect address (combinational)
// OFFSET_W must be 30 or less so the shifted offset fits in 32 bits.
// -----------------------------------------------------------------------------
module branch_target_adder #(
  parameter int OFFSET_W = 8
) (
  input  logic [31:0]         pc_plus4,
  input  logic [OFFSET_W-1:0] offset,
  output logic [31:0]         target
);

  logic [31:0] offset_ext;
  logic [31:0] byte_offset;

  // Sign-extend the word offset, then scale to bytes.
  assign offset_ext  = {{(32-OFFSET_W){offset[OFFSET_W-1]}}, offset};
  assign byte_offset = {offset_ext[29:0], 2'b00};
  assign target      = pc_plus4 + byte_offset;

endmodule

// File: rtl/pc_next_unit.sv
// -----------------------------------------------------------------------------
// pc_next_unit
// Program-counter register and next-PC generator for the single-cycle CPU.
// Feeds the downstream 32-bit next-PC mux: PC_PLUS4 -> input 1, TARGET ->
// input 2, PC_SELECT -> select. Holds the PC while memory stalls (BUSYWAIT)
// and remembers a taken branch/jump that arrives during a stall.
//
// Ports:
//   CLK               in   system clock, rising-edge
//   RESET             in   synchronous active-high reset
//   BUSYWAIT          in   memory stall, PC frozen while high
//   JUMP              in   unconditional jump
//   BRANCH            in   conditional branch (beq)
//   ZERO              in   ALU zero flag
//   OFFSET            in   signed word offset [OFFSET_W-1:0]
//   PC                out  current fetch address
//   PC_PLUS4          out  PC + 4 (combinational)
//   TARGET            out  redirect target (combinational)
//   PC_SELECT         out  1 = TARGET, 0 = PC_PLUS4 (combinational)
//   REDIRECT_PENDING  out  a latched redirect waits for the stall to end
//   RETIRED_CNT       out  PC updates since reset   (PC_NEXT_PERF_EN only)
//   STALL_CNT         out  stalled RUN/HOLD cycles  (PC_NEXT_PERF_EN only)
//   state_dbg         out  current sequencer state
//
// Build option: define PC_NEXT_PERF_EN to add the two performance counters.
// -----------------------------------------------------------------------------
module pc_next_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          OFFSET_W = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                BUSYWAIT,
  input  logic                JUMP,
  input  logic                BRANCH,
  input  logic                ZERO,
  input  logic [OFFSET_W-1:0] OFFSET,
  output logic [31:0]         PC,
  output logic [31:0]         PC_PLUS4,
  output logic [31:0]         TARGET,
  output logic                PC_SELECT,
  output logic                REDIRECT_PENDING,
`ifdef PC_NEXT_PERF_EN
  output logic [31:0]         RETIRED_CNT,
  output logic [31:0]         STALL_CNT,
`endif
  output pc_state_e           state_dbg
);

  pc_state_e   state;
  logic [31:0] pending_target;
  logic [31:0] adder_target;
  logic        take;

  branch_target_adder #(
    .OFFSET_W (OFFSET_W)
  ) u_target_adder (
    .pc_plus4 (PC_PLUS4),
    .offset   (OFFSET),
    .target   (adder_target)
  );

  // Next-PC candidates and select. In HOLD the mux is forced onto the
  // latched target so its output always equals the PC about to be loaded.
  always_comb begin
    PC_PLUS4  = PC + 32'(WORD_BYTES);
    take      = JUMP | (BRANCH & ZERO);
    TARGET    = adder_target;
    PC_SELECT = 1'b0;
    case (state)
      ST_RUN: begin
        PC_SELECT = take;
      end
      ST_HOLD: begin
        TARGET    = pending_target;
        PC_SELECT = 1'b1;
      end
      default: begin
        PC_SELECT = 1'b0;
      end
    endcase
  end

  // Sequencer: BOOT gives instruction memory one full fetch cycle after
  // reset; HOLD parks a redirect that coincided with a stall, ignoring the
  // control inputs because the same instruction is still in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PC               <= RESET_PC;
      state            <= ST_BOOT;
      pending_target   <= 32'h0;
      REDIRECT_PENDING <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (!BUSYWAIT) begin
            PC <= take ? adder_target : PC_PLUS4;
          end else if (take) begin
            pending_target   <= adder_target;
            REDIRECT_PENDING <= 1'b1;
            state            <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!BUSYWAIT) begin
            PC               <= pending_target;
            REDIRECT_PENDING <= 1'b0;
            state            <= ST_RUN;
          end
        end
        default: begin
          // Unused encoding: recover through BOOT.
          state <= ST_BOOT;
        end
      endcase
    end
  end

  assign state_dbg = state;

`ifdef PC_NEXT_PERF_EN
  logic active;

  // RUN and HOLD are the only states in which the PC may move or stall.
  assign active = (state == ST_RUN) || (state == ST_HOLD);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      RETIRED_CNT <= 32'h0;
      STALL_CNT   <= 32'h0;
    end else begin
      if (active && !BUSYWAIT) RETIRED_CNT <= RETIRED_CNT + 32'd1;
      if (active && BUSYWAIT)  STALL_CNT   <= STALL_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_next_unit
// Self-checking bench for pc_next_unit. Two instances share the stimulus:
// dut0 with RESET_PC = 0 and dut1 with RESET_PC = 32'hFFFFFFFC for the
// wrap-around case. Each step drives inputs on the falling edge, queues the
// expected outputs, and compares them 2 ns later, before the next rising edge.
// -----------------------------------------------------------------------------
module tb_pc_next_unit;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       RESET    = 1'b1;
  logic       BUSYWAIT = 1'b0;
  logic       JUMP     = 1'b0;
  logic       BRANCH   = 1'b0;
  logic       ZERO     = 1'b0;
  logic [7:0] OFFSET   = 8'h00;

  logic [31:0] pc0, pc_plus4_0, target0;
  logic        sel0, pend0;
  logic [1:0]  st0;
  logic [31:0] pc1, pc_plus4_1, target1;
  logic        sel1, pend1;
  logic [1:0]  st1;
`ifdef PC_NEXT_PERF_EN
  logic [31:0] retired0, stall0, retired1, stall1;
`endif

  pc_next_unit #(.RESET_PC(32'h0000_0000), .OFFSET_W(8)) dut0 (
    .CLK              (clk),
    .RESET            (RESET),
    .BUSYWAIT         (BUSYWAIT),
    .JUMP             (JUMP),
    .BRANCH           (BRANCH),
    .ZERO             (ZERO),
    .OFFSET           (OFFSET),
    .PC               (pc0),
    .PC_PLUS4         (pc_plus4_0),
    .TARGET           (target0),
    .PC_SELECT        (sel0),
    .REDIRECT_PENDING (pend0),
`ifdef PC_NEXT_PERF_EN
    .RETIRED_CNT      (retired0),
    .STALL_CNT        (stall0),
`endif
    .state_dbg        (st0)
  );

  pc_next_unit #(.RESET_PC(32'hFFFF_FFFC), .OFFSET_W(8)) dut1 (
    .CLK              (clk),
    .RESET            (RESET),
    .BUSYWAIT         (BUSYWAIT),
    .JUMP             (JUMP),
    .BRANCH           (BRANCH),
    .ZERO             (ZERO),
    .OFFSET           (OFFSET),
    .PC               (pc1),
    .PC_PLUS4         (pc_plus4_1),
    .TARGET           (target1),
    .PC_SELECT        (sel1),
    .REDIRECT_PENDING (pend1),
`ifdef PC_NEXT_PERF_EN
    .RETIRED_CNT      (retired1),
    .STALL_CNT        (stall1),
`endif
    .state_dbg        (st1)
  );

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic        rst, busy, jmp, br, zr;
    logic [7:0]  off;
    logic        chk;
    logic [31:0] pc, tgt;
    logic        sel, pend;
    logic [1:0]  st;
  } vec_t;

  typedef struct packed {
    logic        which;
    logic [31:0] pc, tgt;
    logic        sel, pend;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[21];

  function automatic vec_t v(input logic rst, busy, jmp, br, zr,
                             input logic [7:0] off, input logic chk,
                             input logic [31:0] pc, tgt,
                             input logic sel, pend, input logic [1:0] st);
    vec_t r;
    r.rst = rst; r.busy = busy; r.jmp = jmp; r.br = br; r.zr = zr;
    r.off = off; r.chk = chk; r.pc = pc; r.tgt = tgt;
    r.sel = sel; r.pend = pend; r.st = st;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  task automatic check_out();
    exp_t e;
    e = exp_q.pop_front();
    if (e.which == 1'b0) begin
      cmp("dut0 PC",               pc0,         e.pc);
      cmp("dut0 PC_PLUS4",         pc_plus4_0,  e.pc + 32'd4);
      cmp("dut0 TARGET",           target0,     e.tgt);
      cmp("dut0 PC_SELECT",        32'(sel0),   32'(e.sel));
      cmp("dut0 REDIRECT_PENDING", 32'(pend0),  32'(e.pend));
      cmp("dut0 state",            32'(st0),    32'(e.st));
    end else begin
      cmp("dut1 PC",               pc1,         e.pc);
      cmp("dut1 PC_PLUS4",         pc_plus4_1,  e.pc + 32'd4);
      cmp("dut1 TARGET",           target1,     e.tgt);
      cmp("dut1 PC_SELECT",        32'(sel1),   32'(e.sel));
      cmp("dut1 REDIRECT_PENDING", 32'(pend1),  32'(e.pend));
      cmp("dut1 state",            32'(st1),    32'(e.st));
    end
  endtask

  // Driver: one clock cycle of stimulus, then the scoreboard compare.
  task automatic apply(input vec_t t, input logic which);
    exp_t e;
    @(negedge clk);
    RESET    = t.rst;
    BUSYWAIT = t.busy;
    JUMP     = t.jmp;
    BRANCH   = t.br;
    ZERO     = t.zr;
    OFFSET   = t.off;
    if (t.chk) begin
      e.which = which; e.pc = t.pc; e.tgt = t.tgt;
      e.sel = t.sel; e.pend = t.pend; e.st = t.st;
      exp_q.push_back(e);
    end
    #2;
    if (t.chk) check_out();
  endtask

  // ---------------- test ----------------
  initial begin
    // Reset, BOOT, sequential fetch, branch taken / not taken, jump+branch,
    // jump during a 3-cycle stall, reset during HOLD, BOOT ignoring a jump.
    vecs[0]  = v(1,0,0,0,0,8'h00,0,32'h00,32'h00,0,0,S_BOOT);
    vecs[1]  = v(1,0,0,0,0,8'h00,1,32'h00,32'h04,0,0,S_BOOT);
    vecs[2]  = v(0,0,0,0,0,8'h00,1,32'h00,32'h04,0,0,S_BOOT);
    vecs[3]  = v(0,0,0,0,0,8'h00,1,32'h00,32'h04,0,0,S_RUN);
    vecs[4]  = v(0,0,0,0,0,8'h00,1,32'h04,32'h08,0,0,S_RUN);
    vecs[5]  = v(0,0,0,0,0,8'h00,1,32'h08,32'h0C,0,0,S_RUN);
    vecs[6]  = v(0,0,0,0,0,8'h00,1,32'h0C,32'h10,0,0,S_RUN);
    vecs[7]  = v(0,0,0,1,1,8'hFE,1,32'h10,32'h0C,1,0,S_RUN);
    vecs[8]  = v(0,0,0,0,0,8'h00,1,32'h0C,32'h10,0,0,S_RUN);
    vecs[9]  = v(0,0,0,1,0,8'hFE,1,32'h10,32'h0C,0,0,S_RUN);
    vecs[10] = v(0,0,1,1,1,8'h02,1,32'h14,32'h20,1,0,S_RUN);
    vecs[11] = v(0,1,1,0,0,8'h03,1,32'h20,32'h30,1,0,S_RUN);
    vecs[12] = v(0,1,0,0,0,8'h55,1,32'h20,32'h30,1,1,S_HOLD);
    vecs[13] = v(0,1,1,1,1,8'h80,1,32'h20,32'h30,1,1,S_HOLD);
    vecs[14] = v(0,0,0,0,0,8'h00,1,32'h20,32'h30,1,1,S_HOLD);
    vecs[15] = v(0,1,0,0,0,8'h00,1,32'h30,32'h34,0,0,S_RUN);
    vecs[16] = v(0,1,1,0,0,8'h03,1,32'h30,32'h40,1,0,S_RUN);
    vecs[17] = v(1,1,0,0,0,8'h00,1,32'h30,32'h40,1,1,S_HOLD);
    vecs[18] = v(0,0,1,0,0,8'h05,1,32'h00,32'h18,0,0,S_BOOT);
    vecs[19] = v(0,0,0,0,0,8'h00,1,32'h00,32'h04,0,0,S_RUN);
    vecs[20] = v(0,0,0,0,0,8'h00,1,32'h04,32'h08,0,0,S_RUN);

    for (int i = 0; i < 21; i++) apply(vecs[i], 1'b0);

    // Wrap-around on dut1 (RESET_PC = 0xFFFFFFFC).
    apply(v(1,0,0,0,0,8'h00,0,32'h0,32'h0,0,0,S_BOOT), 1'b1);
    apply(v(1,0,0,0,0,8'h00,1,32'hFFFF_FFFC,32'h0000_0000,0,0,S_BOOT), 1'b1);
    apply(v(0,0,0,0,0,8'h00,1,32'hFFFF_FFFC,32'h0000_0000,0,0,S_BOOT), 1'b1);
    apply(v(0,0,0,0,0,8'h00,1,32'hFFFF_FFFC,32'h0000_0000,0,0,S_RUN),  1'b1);
    apply(v(0,0,1,0,0,8'hFD,1,32'h0000_0000,32'hFFFF_FFF8,1,0,S_RUN),  1'b1);
    apply(v(0,0,0,1,1,8'h01,1,32'hFFFF_FFF8,32'h0000_0000,1,0,S_RUN),  1'b1);
    apply(v(0,0,0,0,0,8'h00,1,32'h0000_0000,32'h0000_0004,0,0,S_RUN),  1'b1);

`ifdef PC_NEXT_PERF_EN
    // 5 advances and 3 stall cycles after reset on dut0.
    apply(v(1,0,0,0,0,8'h00,0,32'h0,32'h0,0,0,S_BOOT), 1'b0);
    apply(v(1,0,0,0,0,8'h00,0,32'h0,32'h0,0,0,S_BOOT), 1'b0);
    apply(v(0,0,0,0,0,8'h00,0,32'h0,32'h0,0,0,S_BOOT), 1'b0);
    apply(v(0,0,0,0,0,8'h00,0,32'h0,32'h0,0,0,S_RUN),  1'b0);
    apply(v(0,1,0,0,0,8'h00,0,32'h0,32'h0,0,0,S_RUN),  1'b0);
    apply(v(0,0,0,0,0,8'h00,0,32'h0,32'h0,0,0,S_RUN),  1'b0);
    apply(v(0,1,0,0,0,8'h00,0,32'h0,32'h0,0,0,S_RUN),  1'b0);
    apply(v(0,0,0,0,0,8'h00,0,32'h0,32'h0,0,0,S_RUN),  1'b0);
    apply(v(0,0,0,0,0,8'h00,0,32'h0,32'h0,0,0,S_RUN),  1'b0);
    apply(v(0,1,0,0,0,8'h00,0,32'h0,32'h0,0,0,S_RUN),  1'b0);
    apply(v(0,0,0,0,0,8'h00,0,32'h0,32'h0,0,0,S_RUN),  1'b0);
    apply(v(0,1,0,0,0,8'h00,1,32'h14,32'h18,0,0,S_RUN), 1'b0);
    cmp("RETIRED_CNT", retired0, 32'd5);
    cmp("STALL_CNT",   stall0,   32'd3);
`endif

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter register and next-PC generator for the single-cycle CPU.
- Produces the two 32-bit next-PC candidates and the select line that feed the 32-bit next-PC multiplexer directly downstream:
  - PC_PLUS4 drives mux input 1.
  - TARGET drives mux input 2.
  - PC_SELECT drives the mux select.
- Holds the PC while memory asserts BUSYWAIT, and latches a taken branch/jump that coincides with a stall so the redirect is not lost.

Parameters:
- RESET_PC, 32'h00000000: PC value loaded on reset.
- OFFSET_W, 8: width of the signed word offset from the instruction.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- BUSYWAIT  input  1  memory stall; PC must not advance while high.
- JUMP  input  1  unconditional jump for the current instruction.
- BRANCH  input  1  conditional branch (beq) for the current instruction.
- ZERO  input  1  ALU zero flag.
- OFFSET  input  OFFSET_W  signed word offset.
- PC  output  32  current PC (instruction fetch address).
- PC_PLUS4  output  32  PC + 4.
- TARGET  output  32  redirect target.
- PC_SELECT  output  1  1 = take TARGET, 0 = take PC_PLUS4.
- REDIRECT_PENDING  output  1  high while a latched redirect awaits the end of a stall.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RESET), sampled on the rising edge of CLK; there is no asynchronous path.
- Reset values: PC = RESET_PC, REDIRECT_PENDING = 0, internal pending target = 0, state = BOOT. RESET overrides every other input in every state, including mid-HOLD; any latched redirect is discarded.
- take = JUMP | (BRANCH & ZERO). When JUMP and BRANCH are both high, the result is identical (same target).
- Arithmetic:
  - PC_PLUS4 = PC + 4, modulo 2^32: 32'hFFFFFFFC wraps to 32'h00000000.
  - TARGET in BOOT/RUN = PC_PLUS4 + (sign-extended OFFSET << 2), modulo 2^32.
  - TARGET in HOLD = latched pending target.
- PC_SELECT:
  - RUN: PC_SELECT = take.
  - HOLD: PC_SELECT = 1.
  - BOOT: PC_SELECT = 0.
  - Consequence: the downstream mux output always equals the PC that will be loaded.
- PC_PLUS4, TARGET and PC_SELECT are combinational from PC, state and inputs; zero latency.
- State machine:
  - BOOT: PC held for exactly one cycle after RESET falls, giving instruction memory a full fetch cycle. Next edge goes to RUN regardless of other inputs.
  - RUN, BUSYWAIT=0: PC <= take ? TARGET : PC_PLUS4; stay in RUN.
  - RUN, BUSYWAIT=1, take=0: PC held; stay in RUN.
  - RUN, BUSYWAIT=1, take=1: PC held; pending target <= TARGET; REDIRECT_PENDING <= 1; go to HOLD.
  - HOLD, BUSYWAIT=1: PC held; JUMP/BRANCH/ZERO/OFFSET ignored (same instruction is still in flight).
  - HOLD, BUSYWAIT=0: PC <= pending target; REDIRECT_PENDING <= 0; go to RUN.
- The PC changes only on a rising edge with BUSYWAIT=0 in RUN or HOLD. It never changes in BOOT or under reset.

Optional Feature:
- Macro: PC_NEXT_PERF_EN.
- Defined: adds two outputs, both cleared by RESET and wrapping at 2^32.
  - RETIRED_CNT[31:0]: increments on every PC update.
  - STALL_CNT[31:0]: increments on every RUN/HOLD cycle with BUSYWAIT=1.
- Undefined: neither port nor counter logic exists. All other behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - State encoding: BOOT=2'd0, RUN=2'd1, HOLD=2'd2.
  - WORD_BYTES=4.
  - Default RESET_PC.
- One sub-module: branch_target_adder, which sign-extends OFFSET, shifts it left by 2 and adds it to PC_PLUS4. It is reused by the jump path.

Test Plan:
- Reset then sequential fetch: RESET high for 2 cycles, then low; BUSYWAIT=0, no take.
  - Expected: PC=0 in the reset cycle and the BOOT cycle, then 4, 8, 12 on successive edges. PC_SELECT=0 throughout.
- Branch taken/not taken: PC=0x10, BRANCH=1, OFFSET=8'hFE.
  - ZERO=1 -> TARGET=0x0C, PC_SELECT=1, next PC=0x0C.
  - ZERO=0 -> next PC=0x14.
- Jump during stall: PC=0x20, JUMP=1, OFFSET=3, BUSYWAIT high for 3 cycles.
  - Expected: HOLD entered; REDIRECT_PENDING=1; PC stays 0x20 even if JUMP drops or OFFSET changes.
  - When BUSYWAIT falls: PC=0x30 on the next edge, REDIRECT_PENDING=0.
- Wrap-around: RESET_PC=32'hFFFFFFFC, no take.
  - Expected: after BOOT, PC=0. Forward branch with OFFSET=1 from 0xFFFFFFF8 gives TARGET=0x00000000.
- Reset mid-HOLD: enter HOLD with pending target 0x40, then assert RESET while BUSYWAIT=1.
  - Expected: PC=RESET_PC, REDIRECT_PENDING=0, state BOOT. Target 0x40 never loaded.
- With PC_NEXT_PERF_EN: 5 advances and 3 stall cycles after reset.
  - Expected: RETIRED_CNT=5, STALL_CNT=3.
